// File: rtl/led_frame_shifter.sv
// Serial output stage: takes grayscale words over valid/ready and shifts them MSB-first on o_clk/o_dai.
// Each frame ends with an o_lat pulse and a gap. Optional feature macro: LED_SHIFTER_TEST_PATTERN_EN (adds i_tp).
module led_frame_shifter #(
  parameter int c_freq      = 20000000,
  parameter int c_sclk_freq = 1000000,
  parameter int c_chans     = 12,
  parameter int c_width     = 16,
  parameter int c_lat_cyc   = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef LED_SHIFTER_TEST_PATTERN_EN
  input  logic               i_tp,
`endif
  input  logic [c_width-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_clk,
  output logic               o_dai,
  output logic               o_lat,
  output logic               o_busy
);

  localparam int c_half   = c_freq / (2 * c_sclk_freq);
  localparam int c_half_w = (c_half > 1) ? $clog2(c_half) : 1;
  localparam int c_bit_w  = (c_width > 1) ? $clog2(c_width) : 1;
  localparam int c_word_w = (c_chans > 1) ? $clog2(c_chans) : 1;
  localparam int c_lat_w  = (c_lat_cyc > 1) ? $clog2(c_lat_cyc) : 1;

  localparam logic [c_half_w-1:0] c_half_last = c_half_w'(c_half - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_width - 1);
  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(c_chans - 1);
  localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(c_lat_cyc - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [c_width-1:0]  r_shift;
  logic [c_half_w-1:0] r_half_cnt;
  logic [c_bit_w-1:0]  r_bit_cnt;
  logic [c_word_w-1:0] r_word_cnt;
  logic [c_lat_w-1:0]  r_lat_cnt;
  logic                r_ready;
  logic                r_clk;
  logic                r_dai;
  logic                r_lat;
  logic                r_busy;
  logic                r_tp;

  logic                w_tp;
  logic                w_load;
  logic [c_width-1:0]  w_load_word;

`ifdef LED_SHIFTER_TEST_PATTERN_EN
  assign w_tp = i_tp;
`else
  assign w_tp = 1'b0;
`endif

  // A test-pattern word is the channel index and needs no handshake.
  assign w_load      = (r_state == S_LOAD) && (r_tp || (i_valid && r_ready));
  assign w_load_word = r_tp ? c_width'(r_word_cnt) : i_data;

  // NOTE: every register here uses <= so all decisions in one cycle see the pre-edge state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_lat_cnt  <= '0;
      r_ready    <= 1'b0;
      r_clk      <= 1'b0;
      r_dai      <= 1'b0;
      r_lat      <= 1'b0;
      r_busy     <= 1'b0;
      r_tp       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD;
          r_ready <= !w_tp;
          r_tp    <= w_tp;
        end

        S_LOAD: begin
          r_clk <= 1'b0;
          if (w_load) begin
            r_shift    <= w_load_word;
            r_dai      <= w_load_word[c_width-1];
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_half_cnt <= '0;
            r_state    <= S_SHIFT_LO;
          end
        end

        S_SHIFT_LO: begin
          if (r_half_cnt == c_half_last) begin
            r_half_cnt <= '0;
            r_clk      <= 1'b1;
            r_state    <= S_SHIFT_HI;
          end else begin
            r_half_cnt <= r_half_cnt + c_half_w'(1);
          end
        end

        S_SHIFT_HI: begin
          if (r_half_cnt == c_half_last) begin
            r_half_cnt <= '0;
            r_clk      <= 1'b0;
            if (r_bit_cnt != c_bit_last) begin
              r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
              r_shift   <= {r_shift[c_width-2:0], 1'b0};
              r_dai     <= r_shift[c_width-2];
              r_state   <= S_SHIFT_LO;
            end else if (r_word_cnt != c_word_last) begin
              r_bit_cnt  <= '0;
              r_word_cnt <= r_word_cnt + c_word_w'(1);
              r_ready    <= !w_tp;
              r_tp       <= w_tp;
              r_state    <= S_LOAD;
            end else begin
              r_bit_cnt  <= '0;
              r_word_cnt <= '0;
              r_dai      <= 1'b0;
              r_lat      <= 1'b1;
              r_lat_cnt  <= '0;
              r_state    <= S_LATCH;
            end
          end else begin
            r_half_cnt <= r_half_cnt + c_half_w'(1);
          end
        end

        S_LATCH: begin
          if (r_lat_cnt == c_lat_last) begin
            r_lat_cnt <= '0;
            r_lat     <= 1'b0;
            r_state   <= S_GAP;
          end else begin
            r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
          end
        end

        S_GAP: begin
          if (r_lat_cnt == c_lat_last) begin
            r_lat_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_clk   = r_clk;
  assign o_dai   = r_dai;
  assign o_lat   = r_lat;
  assign o_busy  = r_busy;

endmodule
